// File: rtl/leg_exception_ctrl.sv
// Exception and interrupt sequencer for the LEG core: synchronous exception priority,
// two-cycle data abort, reset vector, and IRQ/FIQ entry after a pipeline drain.
module leg_exception_ctrl #(
    parameter int NUM_IRQ      = 8,
    parameter int DRAIN_STAGES = 3,
    parameter int IRQ_ID_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                DataAbortM,
    input  logic                PrefetchAbortE,
    input  logic                UndefinedInstrE,
    input  logic                SWIE,
    input  logic                FiqReq,
    input  logic [NUM_IRQ-1:0]  IrqReq,
    input  logic [NUM_IRQ-1:0]  IrqMask,
    input  logic [NUM_IRQ-1:0]  IrqClear,
    input  logic                IRQEnabled,
    input  logic                FIQEnabled,
    output logic                PipelineClearF,
    output logic                ExceptionFlushD,
    output logic                ExceptionFlushE,
    output logic                ExceptionFlushM,
    output logic                ExceptionFlushW,
    output logic                ExceptionStallD,
    output logic [6:0]          PCVectorAddress,
    output logic                ExceptionSavePC,
    output logic                IrqAssert,
    output logic                FiqAssert,
    output logic [IRQ_ID_W-1:0] IrqId,
    output logic [NUM_IRQ-1:0]  IrqPending
);

    typedef enum logic [2:0] {
        RST_VEC = 3'd0,
        IDLE    = 3'd1,
        ABORT2  = 3'd2,
        DRAIN   = 3'd3,
        TAKE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_next;
    logic [NUM_IRQ-1:0]    r_irq_prev;
    logic [NUM_IRQ-1:0]    r_pending;
    logic [NUM_IRQ-1:0]    w_active;
    logic                  w_fiq_elig;
    logic                  w_irq_elig;
    logic                  w_sync;
    logic [IRQ_ID_W-1:0]   w_lowest;
    logic                  w_pcf;
    logic [3:0]            w_flush;    // {D, E, M, W}
    logic                  w_stall;
    logic [6:0]            w_vec;
    logic                  w_irqa;
    logic                  w_fiqa;
    logic [IRQ_ID_W-1:0]   w_id;

    assign w_active   = r_pending & ~IrqMask;
    assign w_fiq_elig = FiqReq & FIQEnabled;
    assign w_irq_elig = (|w_active) & IRQEnabled;
    assign w_sync     = PrefetchAbortE | UndefinedInstrE | SWIE;

    // Lowest-index pending and unmasked IRQ line
    always_comb begin
        w_lowest = {IRQ_ID_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_lowest = IRQ_ID_W'(i);
            end else begin
                w_lowest = w_lowest;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_pcf      = 1'b0;
        w_flush    = 4'b0000;
        w_stall    = 1'b0;
        w_vec      = 7'b0000000;
        w_irqa     = 1'b0;
        w_fiqa     = 1'b0;
        w_id       = {IRQ_ID_W{1'b0}};
        case (r_state)
            RST_VEC: begin
                w_vec   = 7'b0000001;
                w_flush = 4'b1111;
                w_next  = IDLE;
            end
            IDLE, DRAIN: begin
                if (DataAbortM) begin
                    w_flush = 4'b1111;
                    w_next  = ABORT2;
                end else if (w_sync) begin
                    // A pending interrupt re-arms from IDLE once the exception is handled
                    if (PrefetchAbortE) begin
                        w_flush = 4'b1110;
                        w_vec   = 7'b0001000;
                    end else if (UndefinedInstrE) begin
                        w_flush = 4'b1110;
                        w_vec   = 7'b0000010;
                    end else begin
                        w_flush = 4'b1000;
                        w_vec   = 7'b0000100;
                    end
                    w_next = IDLE;
                end else if (r_state == DRAIN) begin
                    w_pcf      = 1'b1;
                    w_cnt_next = r_cnt - 3'd1;
                    w_next     = (r_cnt <= 3'd1) ? TAKE : DRAIN;
                end else if (w_fiq_elig || w_irq_elig) begin
                    w_cnt_next = 3'(DRAIN_STAGES);
                    w_next     = DRAIN;
                end else begin
                    w_next = IDLE;
                end
            end
            ABORT2: begin
                if (DataAbortM) begin
                    w_flush = 4'b1111;
                    w_next  = ABORT2;
                end else begin
                    w_vec   = 7'b0000100;
                    w_flush = 4'b1000;
                    w_stall = 1'b1;
                    w_next  = IDLE;
                end
            end
            TAKE: begin
                // Eligibility is re-checked so a late FIQ overtakes the IRQ that started the drain
                if (DataAbortM) begin
                    w_flush = 4'b1111;
                    w_next  = ABORT2;
                end else if (w_fiq_elig) begin
                    w_fiqa  = 1'b1;
                    w_vec   = 7'b1000000;
                    w_flush = 4'b1010;
                    w_pcf   = 1'b1;
                    w_next  = IDLE;
                end else if (w_irq_elig) begin
                    w_irqa  = 1'b1;
                    w_id    = w_lowest;
                    w_vec   = 7'b0100000;
                    w_flush = 4'b1010;
                    w_pcf   = 1'b1;
                    w_next  = IDLE;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = RST_VEC;
            end
        endcase
    end

    // State, drain counter, IRQ edge history and pending register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RST_VEC;
            r_cnt      <= 3'd0;
            r_irq_prev <= {NUM_IRQ{1'b0}};
            r_pending  <= {NUM_IRQ{1'b0}};
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_irq_prev <= IrqReq;
            r_pending  <= (r_pending & ~IrqClear) | (IrqReq & ~r_irq_prev);
        end
    end

    assign PipelineClearF  = w_pcf;
    assign ExceptionFlushD = w_flush[3];
    assign ExceptionFlushE = w_flush[2];
    assign ExceptionFlushM = w_flush[1];
    assign ExceptionFlushW = w_flush[0];
    assign ExceptionStallD = w_stall;
    assign PCVectorAddress = w_vec;
    assign ExceptionSavePC = |w_vec[6:1];
    assign IrqAssert       = w_irqa;
    assign FiqAssert       = w_fiqa;
    assign IrqId           = w_id;
    assign IrqPending      = r_pending;

endmodule
